sram_test_reporter: RTL and testbench

Serial status reporter that sits directly downstream of the SRAM tester. It watches the tester's completion, pass and debug outputs, and snapshots them on each reportable event. It then transmits one ASCII status line over an 8N1 UART TX pin, so board-level SRAM test results are readable from a host terminal without a logic analyzer.

---
 rtl/sram_test_reporter.sv | 200 ++++++++++++++++++++
 tb/tb_sram_test_reporter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_test_reporter.sv
// sram_test_reporter: snapshots the SRAM tester status on every done/fail edge
// and sends one ASCII status line per event over an 8N1 UART.
module sram_test_reporter #(
    parameter int DATA_BITS    = 16,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 test_done,
    input  logic                 test_pass,
    input  logic [2:0]           test_state,
    input  logic [2:0]           pattern_state,
    input  logic [DATA_BITS-1:0] prev_read_data,
    input  logic [DATA_BITS-1:0] prev_expected_data,
    output logic                 uart_tx,
    output logic                 busy,
    output logic                 report_done
);
    localparam int NIB     = DATA_BITS / 4;
    localparam int MSG_MAX = 16 + DATA_BITS / 2;
    localparam int IDX_W   = $clog2(MSG_MAX + 1);
    localparam int CW      = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t                state_q, state_d;
    logic                  done_q, done_d, pass_q, pass_d;
    logic                  pending_q, pending_d;
    logic                  tx_q, tx_d;
    logic                  report_done_q, report_done_d;
    logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]      char_idx_q, char_idx_d;
    logic                  snap_pass_q, snap_pass_d;
    logic [2:0]            snap_tstate_q, snap_tstate_d;
    logic [2:0]            snap_pstate_q, snap_pstate_d;
    logic [DATA_BITS-1:0]  snap_read_q, snap_read_d;
    logic [DATA_BITS-1:0]  snap_exp_q, snap_exp_d;

    logic                  report_event;
    logic                  bit_end;
    logic [IDX_W-1:0]      msg_last;
    logic [7:0]            cur_char;
    logic [DATA_BITS-1:0]  data_sh;
    int                    idx;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    assign report_event = (test_done & ~done_q) | (~test_pass & pass_q);
    assign bit_end      = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
    assign msg_last     = snap_pass_q ? IDX_W'(5) : IDX_W'(MSG_MAX - 1);

    // Character generator driven entirely from the snapshot
    always_comb begin
        cur_char = 8'h20;
        data_sh  = '0;
        idx      = int'(char_idx_q);
        if (snap_pass_q) begin
            case (idx)
                0:       cur_char = 8'h50;
                1:       cur_char = 8'h41;
                2, 3:    cur_char = 8'h53;
                4:       cur_char = 8'h0D;
                default: cur_char = 8'h0A;
            endcase
        end else if (idx < 12) begin
            case (idx)
                0:       cur_char = 8'h46;
                1:       cur_char = 8'h41;
                2:       cur_char = 8'h49;
                3:       cur_char = 8'h4C;
                5:       cur_char = 8'h73;
                6:       cur_char = 8'h30 + {5'b0, snap_tstate_q};
                8:       cur_char = 8'h70;
                9:       cur_char = 8'h30 + {5'b0, snap_pstate_q};
                11:      cur_char = 8'h72;
                default: cur_char = 8'h20;
            endcase
        end else if (idx < 12 + NIB) begin
            data_sh  = snap_read_q >> (4 * (NIB - 1 - (idx - 12)));
            cur_char = hex_char(data_sh[3:0]);
        end else if (idx == 12 + NIB) begin
            cur_char = 8'h20;
        end else if (idx == 13 + NIB) begin
            cur_char = 8'h65;
        end else if (idx < 14 + 2 * NIB) begin
            data_sh  = snap_exp_q >> (4 * (NIB - 1 - (idx - 14 - NIB)));
            cur_char = hex_char(data_sh[3:0]);
        end else if (idx == 14 + 2 * NIB) begin
            cur_char = 8'h0D;
        end else begin
            cur_char = 8'h0A;
        end
    end

    // tx is registered from the current state, so the line lags the FSM by one cycle
    always_comb begin
        state_d       = state_q;
        done_d        = test_done;
        pass_d        = test_pass;
        pending_d     = pending_q;
        tx_d          = 1'b1;
        report_done_d = (state_q == DONE);
        clk_cnt_d     = clk_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        char_idx_d    = char_idx_q;
        snap_pass_d   = snap_pass_q;
        snap_tstate_d = snap_tstate_q;
        snap_pstate_d = snap_pstate_q;
        snap_read_d   = snap_read_q;
        snap_exp_d    = snap_exp_q;

        if (state_q != IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
            if (report_event) pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (report_event || pending_q) begin
                    pending_d     = 1'b0;
                    state_d       = START;
                    clk_cnt_d     = '0;
                    char_idx_d    = '0;
                    snap_pass_d   = test_pass;
                    snap_tstate_d = test_state;
                    snap_pstate_d = pattern_state;
                    snap_read_d   = prev_read_data;
                    snap_exp_d    = prev_expected_data;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                tx_d = cur_char[bit_cnt_q];
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                    else bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (char_idx_q == msg_last) begin
                        state_d = DONE;
                    end else begin
                        char_idx_d = char_idx_q + 1'b1;
                        state_d    = START;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            done_q        <= 1'b0;
            pass_q        <= 1'b1;
            pending_q     <= 1'b0;
            tx_q          <= 1'b1;
            report_done_q <= 1'b0;
            clk_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            char_idx_q    <= '0;
            snap_pass_q   <= 1'b1;
            snap_tstate_q <= '0;
            snap_pstate_q <= '0;
            snap_read_q   <= '0;
            snap_exp_q    <= '0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            pending_q     <= pending_d;
            tx_q          <= tx_d;
            report_done_q <= report_done_d;
            clk_cnt_q     <= clk_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            char_idx_q    <= char_idx_d;
            snap_pass_q   <= snap_pass_d;
            snap_tstate_q <= snap_tstate_d;
            snap_pstate_q <= snap_pstate_d;
            snap_read_q   <= snap_read_d;
            snap_exp_q    <= snap_exp_d;
        end
    end

    assign uart_tx     = tx_q;
    assign busy        = (state_q != IDLE);
    assign report_done = report_done_q;
endmodule

// File: tb/tb_sram_test_reporter.sv
// tb_sram_test_reporter: decodes the UART line and compares characters and
// message timing against expected messages queued when events are driven.
`timescale 1ns/1ps
module tb_sram_test_reporter;
    localparam int DATA_BITS = 16;
    localparam int CPB       = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 test_done;
    logic                 test_pass;
    logic [2:0]           test_state;
    logic [2:0]           pattern_state;
    logic [DATA_BITS-1:0] prev_read_data;
    logic [DATA_BITS-1:0] prev_expected_data;
    logic                 uart_tx;
    logic                 busy;
    logic                 report_done;

    sram_test_reporter #(.DATA_BITS(DATA_BITS), .CLKS_PER_BIT(CPB)) dut (
        .clk                (clk),
        .reset              (reset),
        .test_done          (test_done),
        .test_pass          (test_pass),
        .test_state         (test_state),
        .pattern_state      (pattern_state),
        .prev_read_data     (prev_read_data),
        .prev_expected_data (prev_expected_data),
        .uart_tx            (uart_tx),
        .busy               (busy),
        .report_done        (report_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int num_checks = 0;
    int num_errors = 0;

    typedef struct { int len; int start; } msg_t;
    logic [7:0] exp_bytes[$];
    msg_t       exp_msgs[$];
    string      hx = "0123456789ABCDEF";

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_bytes.push_back(s.getc(i));
    endtask

    task automatic push_hex(input logic [DATA_BITS-1:0] v);
        for (int i = DATA_BITS / 4 - 1; i >= 0; i--)
            exp_bytes.push_back(hx.getc(int'((v >> (4 * i)) & 'hF)));
    endtask

    task automatic push_msg(input logic pass, input logic [2:0] ts, input logic [2:0] ps,
                            input logic [DATA_BITS-1:0] rd, input logic [DATA_BITS-1:0] ed,
                            input int start);
        msg_t m;
        int   n0;
        n0 = exp_bytes.size();
        if (pass) begin
            push_str("PASS");
        end else begin
            push_str("FAIL s");
            exp_bytes.push_back(hx.getc(int'(ts)));
            push_str(" p");
            exp_bytes.push_back(hx.getc(int'(ps)));
            push_str(" r");
            push_hex(rd);
            push_str(" e");
            push_hex(ed);
        end
        exp_bytes.push_back(8'h0D);
        exp_bytes.push_back(8'h0A);
        m.len   = exp_bytes.size() - n0;
        m.start = start;
        exp_msgs.push_back(m);
    endtask

    task automatic applyStimulus(input logic done, input logic pass, input logic [2:0] ts,
                                 input logic [2:0] ps, input logic [DATA_BITS-1:0] rd,
                                 input logic [DATA_BITS-1:0] ed);
        @(posedge clk);
        #1;
        test_done          = done;
        test_pass          = pass;
        test_state         = ts;
        pattern_state      = ps;
        prev_read_data     = rd;
        prev_expected_data = ed;
    endtask

    task automatic wait_edge(input int n);
        wait (cyc >= n);
        #1;
    endtask

    task automatic sample_at(input int n);
        wait (cyc >= n);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        @(negedge clk);
        while (!(busy === 1'b0 && exp_msgs.size() == 0 && exp_bytes.size() == 0) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cycles) checkOutput("idle_timeout", 1, 0);
    endtask

    // UART decoder: every bit must hold its level for exactly CPB samples
    typedef enum int {M_IDLE, M_START, M_DATA, M_STOP} mon_t;
    mon_t       mst = M_IDLE;
    int         mcnt, bidx, bad_samples, bytes_seen, msg_start;
    logic       in_msg = 1'b0;
    logic       cur_bit;
    logic [7:0] rx_byte;
    msg_t       mon_msg;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            mst        = M_IDLE;
            in_msg     = 1'b0;
            bytes_seen = 0;
        end else begin
            if (report_done === 1'b1) begin
                if (exp_msgs.size() == 0) begin
                    checkOutput("unexpected_report", 1, 0);
                end else begin
                    mon_msg = exp_msgs.pop_front();
                    checkOutput("msg_chars", bytes_seen, mon_msg.len);
                    checkOutput("msg_duration", cyc - msg_start, 10 * mon_msg.len * CPB);
                end
                in_msg     = 1'b0;
                bytes_seen = 0;
            end
            case (mst)
                M_IDLE: begin
                    if (uart_tx === 1'b0) begin
                        if (!in_msg) begin
                            in_msg    = 1'b1;
                            msg_start = cyc;
                            if (exp_msgs.size() == 0) checkOutput("unexpected_msg", 1, 0);
                            else checkOutput("msg_start", cyc, exp_msgs[0].start);
                        end
                        mst         = M_START;
                        mcnt        = 1;
                        bad_samples = 0;
                    end
                end
                M_START: begin
                    if (uart_tx !== 1'b0) bad_samples++;
                    mcnt++;
                    if (mcnt == CPB) begin
                        mst  = M_DATA;
                        mcnt = 0;
                        bidx = 0;
                    end
                end
                M_DATA: begin
                    if (mcnt == 0) cur_bit = uart_tx;
                    else if (uart_tx !== cur_bit) bad_samples++;
                    mcnt++;
                    if (mcnt == CPB) begin
                        rx_byte = {cur_bit, rx_byte[7:1]};
                        bidx++;
                        mcnt = 0;
                        if (bidx == 8) mst = M_STOP;
                    end
                end
                default: begin
                    if (uart_tx !== 1'b1) bad_samples++;
                    mcnt++;
                    if (mcnt == CPB) begin
                        checkOutput("bit_shape", bad_samples, 0);
                        if (exp_bytes.size() == 0) checkOutput("extra_char", 32'(rx_byte), 32'hFFFF_FFFF);
                        else checkOutput("char", 32'(rx_byte), 32'(exp_bytes.pop_front()));
                        bytes_seen++;
                        mst = M_IDLE;
                    end
                end
            endcase
        end
    end

    initial begin
        int s1, s2, s3, r, bad;
        reset = 1'b0; test_done = 1'b0; test_pass = 1'b1; test_state = '0;
        pattern_state = '0; prev_read_data = '0; prev_expected_data = '0;

        sample_at(2);
        checkOutput("rst_tx", 32'(uart_tx), 1);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_report_done", 32'(report_done), 0);
        wait_edge(3);
        reset = 1'b1;

        $display("[TB] pass report");
        wait_edge(9);
        test_done = 1'b1;
        push_msg(1'b1, 3'd0, 3'd0, '0, '0, 11);
        sample_at(9);
        checkOutput("busy_before_event", 32'(busy), 0);
        sample_at(10);
        checkOutput("busy_at_event", 32'(busy), 1);
        checkOutput("tx_at_event", 32'(uart_tx), 1);
        sample_at(250);
        checkOutput("busy_last", 32'(busy), 1);
        checkOutput("report_early", 32'(report_done), 0);
        sample_at(251);
        checkOutput("report_pulse", 32'(report_done), 1);
        checkOutput("busy_fall", 32'(busy), 0);
        sample_at(252);
        checkOutput("report_width", 32'(report_done), 0);
        wait_idle(300);

        $display("[TB] fail report with snapshot hold");
        applyStimulus(1'b0, 1'b1, 3'd3, 3'd6, 16'hBEEF, 16'h1234);
        applyStimulus(1'b0, 1'b0, 3'd3, 3'd6, 16'hBEEF, 16'h1234);
        s1 = cyc + 2;
        push_msg(1'b0, 3'd3, 3'd6, 16'hBEEF, 16'h1234, s1);
        wait_edge(s1 + 3 * 10 * CPB + 6);
        applyStimulus(1'b0, 1'b0, 3'd3, 3'd6, 16'h0000, 16'h1234);
        wait_idle(1500);

        $display("[TB] pending merge");
        applyStimulus(1'b0, 1'b1, 3'd5, 3'd2, 16'hA5C3, 16'h0F0F);
        applyStimulus(1'b0, 1'b0, 3'd5, 3'd2, 16'hA5C3, 16'h0F0F);
        s1 = cyc + 2;
        push_msg(1'b0, 3'd5, 3'd2, 16'hA5C3, 16'h0F0F, s1);
        wait_edge(s1 + 100);
        applyStimulus(1'b1, 1'b0, 3'd5, 3'd2, 16'hA5C3, 16'h0F0F);
        s2 = s1 + 10 * 24 * CPB + 2;
        push_msg(1'b0, 3'd5, 3'd2, 16'hA5C3, 16'h0F0F, s2);
        wait_edge(s1 + 300);
        applyStimulus(1'b1, 1'b1, 3'd5, 3'd2, 16'hA5C3, 16'h0F0F);
        applyStimulus(1'b1, 1'b0, 3'd5, 3'd2, 16'hA5C3, 16'h0F0F);
        wait_edge(s2 + 20);
        applyStimulus(1'b1, 1'b0, 3'd4, 3'd1, 16'h7E19, 16'h0F0F);
        wait_edge(s2 + 100);
        applyStimulus(1'b1, 1'b1, 3'd4, 3'd1, 16'h7E19, 16'h0F0F);
        applyStimulus(1'b1, 1'b0, 3'd4, 3'd1, 16'h7E19, 16'h0F0F);
        s3 = s2 + 10 * 24 * CPB + 2;
        push_msg(1'b0, 3'd4, 3'd1, 16'h7E19, 16'h0F0F, s3);
        wait_edge(s2 + 400);
        applyStimulus(1'b1, 1'b1, 3'd4, 3'd1, 16'h7E19, 16'h0F0F);
        applyStimulus(1'b1, 1'b0, 3'd4, 3'd1, 16'h7E19, 16'h0F0F);
        wait_idle(3000);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checkOutput("quiet_after_merge", bad, 0);

        $display("[TB] reset abort");
        applyStimulus(1'b0, 1'b1, 3'd1, 3'd7, 16'hC0DE, 16'hF00D);
        applyStimulus(1'b0, 1'b0, 3'd1, 3'd7, 16'hC0DE, 16'hF00D);
        s1 = cyc + 2;
        push_msg(1'b0, 3'd1, 3'd7, 16'hC0DE, 16'hF00D, s1);
        wait_edge(s1 + 10 * CPB + 3 * CPB);
        reset = 1'b0;
        #1;
        checkOutput("abort_tx", 32'(uart_tx), 1);
        checkOutput("abort_busy", 32'(busy), 0);
        exp_bytes.delete();
        exp_msgs.delete();
        applyStimulus(1'b1, 1'b0, 3'd1, 3'd7, 16'hC0DE, 16'hF00D);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort_hold_tx", 32'(uart_tx), 1);
        checkOutput("abort_report_done", 32'(report_done), 0);
        reset = 1'b1;
        r = cyc;
        push_msg(1'b0, 3'd1, 3'd7, 16'hC0DE, 16'hF00D, r + 2);
        wait_idle(1500);

        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) bad++;
        end
        checkOutput("final_idle_line", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end
endmodule
